// File: rtl/alu_reservation_station.sv
// ALU reservation station: dispatch into free slots, CDB wakeup, one ready op issued per cycle.
// Define RS_AGE_SEL_EN for oldest-first selection; default is lowest-index-ready priority.
module alu_reservation_station #(
    parameter int unsigned      ENTRIES  = 8,
    parameter int unsigned      TAG_W    = 4,
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      OP_W     = 5,
    parameter logic [TAG_W-1:0] TAG_FREE = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alu_in_en,
    input  logic [3*TAG_W+2*DATA_W+OP_W-1:0] alu_in_data,
    output logic                            rs_full,
    input  logic                            cdb_valid,
    input  logic [TAG_W-1:0]                cdb_tag,
    input  logic [DATA_W-1:0]               cdb_data,
    input  logic                            flush,
    input  logic                            issue_stall,
    output logic                            issue_valid,
    output logic [OP_W-1:0]                 issue_op,
    output logic [DATA_W-1:0]               issue_a,
    output logic [DATA_W-1:0]               issue_b,
    output logic [TAG_W-1:0]                issue_dest
);
    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned OFF_D1 = OP_W;
    localparam int unsigned OFF_T1 = OFF_D1 + DATA_W;
    localparam int unsigned OFF_D2 = OFF_T1 + TAG_W;
    localparam int unsigned OFF_T2 = OFF_D2 + DATA_W;
    localparam int unsigned OFF_DS = OFF_T2 + TAG_W;

    logic [ENTRIES-1:0] valid_q, valid_d, ready;
    logic [OP_W-1:0]    op_q    [ENTRIES];
    logic [OP_W-1:0]    op_d    [ENTRIES];
    logic [TAG_W-1:0]   dest_q  [ENTRIES];
    logic [TAG_W-1:0]   dest_d  [ENTRIES];
    logic [TAG_W-1:0]   tag1_q  [ENTRIES];
    logic [TAG_W-1:0]   tag1_d  [ENTRIES];
    logic [TAG_W-1:0]   tag2_q  [ENTRIES];
    logic [TAG_W-1:0]   tag2_d  [ENTRIES];
    logic [DATA_W-1:0]  data1_q [ENTRIES];
    logic [DATA_W-1:0]  data1_d [ENTRIES];
    logic [DATA_W-1:0]  data2_q [ENTRIES];
    logic [DATA_W-1:0]  data2_d [ENTRIES];

    logic              issue_valid_q, issue_valid_d;
    logic [OP_W-1:0]   issue_op_q, issue_op_d;
    logic [DATA_W-1:0] issue_a_q, issue_a_d, issue_b_q, issue_b_d;
    logic [TAG_W-1:0]  issue_dest_q, issue_dest_d;

    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_d1, in_d2;
    logic [TAG_W-1:0]  in_t1, in_t2, in_dest;
    logic              cdb_hit, in_t1_hit, in_t2_hit;
    logic              free_found, sel_found, do_disp, do_issue;
    logic [IDX_W-1:0]  free_idx, sel_idx;

    assign in_op   = alu_in_data[OP_W-1:0];
    assign in_d1   = alu_in_data[OFF_D1 +: DATA_W];
    assign in_t1   = alu_in_data[OFF_T1 +: TAG_W];
    assign in_d2   = alu_in_data[OFF_D2 +: DATA_W];
    assign in_t2   = alu_in_data[OFF_T2 +: TAG_W];
    assign in_dest = alu_in_data[OFF_DS +: TAG_W];

    // A broadcast of the "no producer" tag must never wake anything.
    assign cdb_hit   = cdb_valid && (cdb_tag != TAG_FREE);
    assign in_t1_hit = cdb_hit && (in_t1 == cdb_tag);
    assign in_t2_hit = cdb_hit && (in_t2 == cdb_tag);

    assign rs_full  = &valid_q;
    assign do_disp  = alu_in_en && !rs_full && !flush;
    assign do_issue = sel_found && !issue_stall && !flush;

    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            ready[i] = valid_q[i] && (tag1_q[i] == TAG_FREE) && (tag2_q[i] == TAG_FREE);
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RS_AGE_SEL_EN
    // age_q[i][j] set: slot j was dispatched before slot i and is still live.
    logic [ENTRIES-1:0] age_q [ENTRIES];
    logic [ENTRIES-1:0] age_d [ENTRIES];
    logic [ENTRIES-1:0] iss_mask;

    always_comb begin
        iss_mask = '0;
        if (do_issue) iss_mask[sel_idx] = 1'b1;
        for (int unsigned i = 0; i < ENTRIES; i++) age_d[i] = age_q[i] & ~iss_mask;
        if (do_disp) age_d[free_idx] = valid_q & ~iss_mask;
        if (flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) age_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) age_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) age_q[i] <= age_d[i];
        end
    end
`endif

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
`ifdef RS_AGE_SEL_EN
            if (ready[i] && ((age_q[i] & ready) == '0)) begin
`else
            if (ready[i] && !sel_found) begin
`endif
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        dest_d  = dest_q;
        tag1_d  = tag1_q;
        data1_d = data1_q;
        tag2_d  = tag2_q;
        data2_d = data2_q;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && cdb_hit && (tag1_q[i] == cdb_tag)) begin
                tag1_d[i]  = TAG_FREE;
                data1_d[i] = cdb_data;
            end
            if (valid_q[i] && cdb_hit && (tag2_q[i] == cdb_tag)) begin
                tag2_d[i]  = TAG_FREE;
                data2_d[i] = cdb_data;
            end
        end
        if (do_issue) valid_d[sel_idx] = 1'b0;
        if (do_disp) begin
            valid_d[free_idx] = 1'b1;
            op_d[free_idx]    = in_op;
            dest_d[free_idx]  = in_dest;
            tag1_d[free_idx]  = in_t1_hit ? TAG_FREE : in_t1;
            data1_d[free_idx] = in_t1_hit ? cdb_data : in_d1;
            tag2_d[free_idx]  = in_t2_hit ? TAG_FREE : in_t2;
            data2_d[free_idx] = in_t2_hit ? cdb_data : in_d2;
        end
        if (flush) valid_d = '0;
    end

    always_comb begin
        issue_valid_d = do_issue;
        issue_op_d    = issue_op_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_dest_d  = issue_dest_q;
        if (do_issue) begin
            issue_op_d   = op_q[sel_idx];
            issue_a_d    = data1_q[sel_idx];
            issue_b_d    = data2_q[sel_idx];
            issue_dest_d = dest_q[sel_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_dest_q  <= '0;
        end else begin
            valid_q       <= valid_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_dest_q  <= issue_dest_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q    <= op_d;
        dest_q  <= dest_d;
        tag1_q  <= tag1_d;
        data1_q <= data1_d;
        tag2_q  <= tag2_d;
        data2_q <= data2_d;
    end

    assign issue_valid = issue_valid_q;
    assign issue_op    = issue_op_q;
    assign issue_a     = issue_a_q;
    assign issue_b     = issue_b_q;
    assign issue_dest  = issue_dest_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: vector table plus hand-written multi-cycle sequences.
module tb_alu_reservation_station;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    logic                             clk = 1'b0;
    logic                             rst = 1'b0;
    logic                             alu_in_en = 1'b0;
    logic [3*TAG_W+2*DATA_W+OP_W-1:0] alu_in_data = '0;
    logic                             rs_full;
    logic                             cdb_valid = 1'b0;
    logic [TAG_W-1:0]                 cdb_tag = '0;
    logic [DATA_W-1:0]                cdb_data = '0;
    logic                             flush = 1'b0;
    logic                             issue_stall = 1'b0;
    logic                             issue_valid;
    logic [OP_W-1:0]                  issue_op;
    logic [DATA_W-1:0]                issue_a, issue_b;
    logic [TAG_W-1:0]                 issue_dest;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_reservation_station #(
        .ENTRIES (8),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .OP_W    (OP_W),
        .TAG_FREE(4'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_in_en  (alu_in_en),
        .alu_in_data(alu_in_data),
        .rs_full    (rs_full),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .flush      (flush),
        .issue_stall(issue_stall),
        .issue_valid(issue_valid),
        .issue_op   (issue_op),
        .issue_a    (issue_a),
        .issue_b    (issue_b),
        .issue_dest (issue_dest)
    );

    typedef struct {
        logic        en;
        logic [4:0]  op;
        logic [31:0] d1;
        logic [3:0]  t1;
        logic [31:0] d2;
        logic [3:0]  t2;
        logic [3:0]  dest;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cd;
        logic        ev;
        logic [4:0]  eop;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  edst;
        logic        ef;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic en, input logic [4:0] op, input logic [31:0] d1, input logic [3:0] t1,
                       input logic [31:0] d2, input logic [3:0] t2, input logic [3:0] dest,
                       input logic cv, input logic [3:0] ct, input logic [31:0] cd,
                       input logic ev, input logic [4:0] eop, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [3:0] edst, input logic ef);
        vec_t v;
        v.en = en; v.op = op; v.d1 = d1; v.t1 = t1; v.d2 = d2; v.t2 = t2; v.dest = dest;
        v.cv = cv; v.ct = ct; v.cd = cd;
        v.ev = ev; v.eop = eop; v.ea = ea; v.eb = eb; v.edst = edst; v.ef = ef;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_issue(input string nm, input logic ev, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] dest);
        chk({nm, ".valid"}, 32'(issue_valid), 32'(ev));
        if (ev) begin
            chk({nm, ".op"},   32'(issue_op),   32'(op));
            chk({nm, ".a"},    issue_a,         a);
            chk({nm, ".b"},    issue_b,         b);
            chk({nm, ".dest"}, 32'(issue_dest), 32'(dest));
        end
    endtask

    task automatic drive(input logic en, input logic [4:0] op, input logic [31:0] d1, input logic [3:0] t1,
                         input logic [31:0] d2, input logic [3:0] t2, input logic [3:0] dest);
        alu_in_en   = en;
        alu_in_data = {dest, t2, d2, t1, d1, op};
    endtask

    task automatic cdb(input logic v, input logic [3:0] t, input logic [31:0] d);
        cdb_valid = v;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        cdb(1'b0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.valid", 32'(issue_valid), 32'd0);
        chk("rst.full",  32'(rs_full),     32'd0);
        chk("rst.op",    32'(issue_op),    32'd0);
        chk("rst.a",     issue_a,          32'd0);
        chk("rst.b",     issue_b,          32'd0);
        chk("rst.dest",  32'(issue_dest),  32'd0);
        rst = 1'b1;

        // Ready dispatch and issue latency
        add(1'b1, 5'd1, 32'd5, '0, 32'd7, '0, 4'd3,  1'b0, '0, '0,  1'b0, '0, '0, '0, '0, 1'b0);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b0, '0, '0,  1'b1, 5'd1, 32'd5, 32'd7, 4'd3, 1'b0);
        // Pending tag1 woken three edges after dispatch
        add(1'b1, 5'd2, 32'hDEAD, 4'd2, 32'd1, '0, 4'd4, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b0);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b0, '0, '0,  1'b0, '0, '0, '0, '0, 1'b0);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b0, '0, '0,  1'b0, '0, '0, '0, '0, 1'b0);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b1, 4'd2, 32'h10, 1'b0, '0, '0, '0, '0, 1'b0);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b0, '0, '0,  1'b1, 5'd2, 32'h10, 32'd1, 4'd4, 1'b0);
        // Capture on dispatch
        add(1'b1, 5'd2, 32'hDEAD, 4'd2, 32'd1, '0, 4'd4, 1'b1, 4'd2, 32'h20, 1'b0, '0, '0, '0, '0, 1'b0);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b0, '0, '0,  1'b1, 5'd2, 32'h20, 32'd1, 4'd4, 1'b0);
        // CDB carrying the free tag is ignored
        add(1'b1, 5'd3, 32'd9, '0, '0, 4'd7, 4'd5,  1'b1, '0, 32'h55, 1'b0, '0, '0, '0, '0, 1'b0);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b1, '0, 32'h77, 1'b0, '0, '0, '0, '0, 1'b0);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b1, 4'd7, 32'h8, 1'b0, '0, '0, '0, '0, 1'b0);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b0, '0, '0,  1'b1, 5'd3, 32'd9, 32'd8, 4'd5, 1'b0);
        // Fill all slots with pending ops (slot i waits on tag i+1)
        for (int i = 0; i < 8; i++)
            add(1'b1, 5'(i), '0, 4'(i + 1), 32'h100 + 32'(i), '0, 4'(i + 8),
                1'b0, '0, '0, 1'b0, '0, '0, '0, '0, (i == 7));
        add(1'b1, 5'h1F, 32'hBAD, '0, '0, '0, 4'd1,  1'b0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b1);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b1, 4'd6, 32'h50, 1'b0, '0, '0, '0, '0, 1'b1);
        add(1'b1, 5'h1D, 32'd1, '0, 32'd2, '0, 4'd1, 1'b0, '0, '0, 1'b1, 5'd5, 32'h50, 32'h105, 4'd13, 1'b0);
        add(1'b1, 5'h1E, 32'h11, '0, 32'h22, '0, 4'd2, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b1);
        add(1'b0, '0, '0, '0, '0, '0, '0,           1'b0, '0, '0,  1'b1, 5'h1E, 32'h11, 32'h22, 4'd2, 1'b0);

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].op, vq[i].d1, vq[i].t1, vq[i].d2, vq[i].t2, vq[i].dest);
            cdb(vq[i].cv, vq[i].ct, vq[i].cd);
            step();
            chk_issue($sformatf("vec%0d", i), vq[i].ev, vq[i].eop, vq[i].ea, vq[i].eb, vq[i].edst);
            chk($sformatf("vec%0d.full", i), 32'(rs_full), 32'(vq[i].ef));
        end
        idle();

        // Flush with seven pending slots and a concurrent ready dispatch
        flush = 1'b1;
        drive(1'b1, 5'h1C, 32'h3, '0, 32'h4, '0, 4'd6);
        step();
        flush = 1'b0;
        idle();
        chk("flush.valid", 32'(issue_valid), 32'd0);
        chk("flush.full",  32'(rs_full),     32'd0);
        for (int k = 1; k <= 8; k++) begin
            cdb(1'b1, 4'(k), 32'hF0 + 32'(k));
            step();
            chk($sformatf("postflush%0d.valid", k), 32'(issue_valid), 32'd0);
        end
        idle();
        step();
        chk("postflush.idle", 32'(issue_valid), 32'd0);

        // Stall with two ready ops; older op sits in the higher slot
        drive(1'b1, 5'd1, 32'hA1, '0, '0, '0, 4'd1);
        step();
        chk_issue("stl.s1", 1'b0, '0, '0, '0, '0);
        drive(1'b1, 5'd2, 32'hB1, 4'd9, '0, '0, 4'd2);
        step();
        chk_issue("stl.s2", 1'b1, 5'd1, 32'hA1, 32'd0, 4'd1);
        issue_stall = 1'b1;
        drive(1'b1, 5'd3, 32'hC1, '0, '0, '0, 4'd3);
        cdb(1'b1, 4'd9, 32'hB2);
        step();
        idle();
        chk_issue("stl.s3", 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_issue($sformatf("stl.hold%0d", k), 1'b0, '0, '0, '0, '0);
        end
        issue_stall = 1'b0;
        step();
`ifdef RS_AGE_SEL_EN
        chk_issue("stl.first",  1'b1, 5'd2, 32'hB2, 32'd0, 4'd2);
        step();
        chk_issue("stl.second", 1'b1, 5'd3, 32'hC1, 32'd0, 4'd3);
`else
        chk_issue("stl.first",  1'b1, 5'd3, 32'hC1, 32'd0, 4'd3);
        step();
        chk_issue("stl.second", 1'b1, 5'd2, 32'hB2, 32'd0, 4'd2);
`endif
        step();
        chk_issue("stl.drain", 1'b0, '0, '0, '0, '0);
        chk("stl.full", 32'(rs_full), 32'd0);

        // Asynchronous reset in the middle of issuing
        drive(1'b1, 5'd7, 32'h70, '0, 32'h71, '0, 4'd7);
        step();
        drive(1'b1, 5'd8, 32'h80, '0, 32'h81, '0, 4'd8);
        step();
        idle();
        chk_issue("ar.pre", 1'b1, 5'd7, 32'h70, 32'h71, 4'd7);
        #2;
        rst = 1'b0;
        #1;
        chk("ar.valid", 32'(issue_valid), 32'd0);
        chk("ar.full",  32'(rs_full),     32'd0);
        chk("ar.op",    32'(issue_op),    32'd0);
        chk("ar.a",     issue_a,          32'd0);
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ar.post%0d", k), 32'(issue_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
